imm_extend_pipe: RTL and testbench

Registered, parametrised immediate-extraction stage for the pipelined LEGv8 core. Sits between the IF/ID register and the register-read stage. Each cycle it:
- decodes the opcode of one accepted instruction;
- produces a DATA_WIDTH-bit extended immediate plus a format tag;
- flags unrecognised opcodes and counts them.

A two-entry skid buffer with a valid/ready handshake decouples it from downstream stalls. A flush clears all in-flight work.

---
 rtl/imm_extend_pipe.sv | 132 +++++++++++++
 tb/tb_imm_extend_pipe.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate-extraction stage: decode, extend, and buffer through a two-entry skid.
// Define IMM_EXTEND_BRANCH_SHIFT_EN to emit B/CB immediates as byte offsets (<<2).
module imm_extend_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [2:0]            out_kind,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  illegal_count
);

  if (DATA_WIDTH < 32) begin : g_width_check
    $error("imm_extend_pipe: DATA_WIDTH must be at least 32");
  end

  localparam logic [2:0] KIND_NONE = 3'd0;
  localparam logic [2:0] KIND_R    = 3'd1;
  localparam logic [2:0] KIND_D    = 3'd2;
  localparam logic [2:0] KIND_CB   = 3'd3;
  localparam logic [2:0] KIND_B    = 3'd4;
  localparam logic [2:0] KIND_I    = 3'd5;

  logic [DATA_WIDTH-1:0] dec_imm;
  logic [2:0]            dec_kind;
  logic                  dec_illegal;

  logic                  main_valid, skid_valid;
  logic [DATA_WIDTH-1:0] main_imm, skid_imm;
  logic [2:0]            main_kind, skid_kind;
  logic                  main_illegal, skid_illegal;

  logic accept, issue;

  // First matching format wins; an unmatched opcode yields kind 0, imm 0.
  always_comb begin
    dec_imm     = '0;
    dec_kind    = KIND_NONE;
    dec_illegal = 1'b0;
    if (instr[31:26] == 6'b000101 || instr[31:26] == 6'b100101) begin
      dec_kind = KIND_B;
`ifdef IMM_EXTEND_BRANCH_SHIFT_EN
      dec_imm  = {{(DATA_WIDTH-28){instr[25]}}, instr[25:0], 2'b00};
`else
      dec_imm  = {{(DATA_WIDTH-26){instr[25]}}, instr[25:0]};
`endif
    end else if (instr[31:24] == 8'h54 || instr[31:24] == 8'hB4 || instr[31:24] == 8'hB5) begin
      dec_kind = KIND_CB;
`ifdef IMM_EXTEND_BRANCH_SHIFT_EN
      dec_imm  = {{(DATA_WIDTH-21){instr[23]}}, instr[23:5], 2'b00};
`else
      dec_imm  = {{(DATA_WIDTH-19){instr[23]}}, instr[23:5]};
`endif
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      dec_kind = KIND_I;
      dec_imm  = {{(DATA_WIDTH-12){1'b0}}, instr[21:10]};
    end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
      dec_kind = KIND_D;
      dec_imm  = {{(DATA_WIDTH-9){instr[20]}}, instr[20:12]};
    end else if (instr[31:21] == 11'b11010011011 || instr[31:21] == 11'b11010011010) begin
      dec_kind = KIND_R;
      dec_imm  = {{(DATA_WIDTH-6){1'b0}}, instr[15:10]};
    end else begin
      dec_illegal = 1'b1;
    end
  end

  assign in_ready    = ~skid_valid;
  assign accept      = in_valid & in_ready & ~flush;
  assign issue       = main_valid & out_ready & ~flush;
  assign out_valid   = main_valid;
  assign out_imm     = main_imm;
  assign out_kind    = main_kind;
  assign out_illegal = main_illegal;

  // Skid can only be full when in_ready is low, so it never fills on the same edge it drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid    <= 1'b0;
      skid_valid    <= 1'b0;
      main_imm      <= '0;
      main_kind     <= KIND_NONE;
      main_illegal  <= 1'b0;
      skid_imm      <= '0;
      skid_kind     <= KIND_NONE;
      skid_illegal  <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (issue) begin
        if (skid_valid) begin
          main_imm     <= skid_imm;
          main_kind    <= skid_kind;
          main_illegal <= skid_illegal;
          skid_valid   <= 1'b0;
        end else if (accept) begin
          main_imm     <= dec_imm;
          main_kind    <= dec_kind;
          main_illegal <= dec_illegal;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!main_valid) begin
          main_valid   <= 1'b1;
          main_imm     <= dec_imm;
          main_kind    <= dec_kind;
          main_illegal <= dec_illegal;
        end else begin
          skid_valid   <= 1'b1;
          skid_imm     <= dec_imm;
          skid_kind    <= dec_kind;
          skid_illegal <= dec_illegal;
        end
      end
      if (accept && dec_illegal && illegal_count != {CNT_WIDTH{1'b1}}) begin
        illegal_count <= illegal_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (DATA_WIDTH=64, CNT_WIDTH=4).
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] instr;
  logic [63:0] out_imm;
  logic [2:0]  out_kind;
  logic [3:0]  illegal_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt;

  imm_extend_pipe #(.DATA_WIDTH(64), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_kind(out_kind), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] bimm(input logic [63:0] v);
`ifdef IMM_EXTEND_BRANCH_SHIFT_EN
    return v << 2;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
    step();
    in_valid = 1'b0;
  endtask

  task automatic expectOut(input string tag, input logic [2:0] kind, input logic [63:0] imm, input logic ill);
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, ".kind"}, 64'(out_kind), 64'(kind));
    checkOutput({tag, ".imm"}, out_imm, imm);
    checkOutput({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    step(); step();
    reset = 1'b0;
    checkOutput("rst.valid", 64'(out_valid), 64'd0);
    checkOutput("rst.in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst.imm", out_imm, 64'd0);
    checkOutput("rst.kind", 64'(out_kind), 64'd0);
    checkOutput("rst.illegal", 64'(out_illegal), 64'd0);
    checkOutput("rst.count", 64'(illegal_count), 64'd0);

    // One instruction of each format, streaming at full rate
    out_ready = 1'b1;
    applyStimulus(32'hF85FF041); expectOut("ldur", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    applyStimulus(32'h14000004); expectOut("b", 3'd4, bimm(64'h4), 1'b0);
    applyStimulus(32'h913FFC41); expectOut("addi", 3'd5, 64'hFFF, 1'b0);
    applyStimulus(32'h54000043); expectOut("cb_pos", 3'd3, bimm(64'h2), 1'b0);
    applyStimulus(32'hB4FFFFE0); expectOut("cb_neg", 3'd3, bimm(64'hFFFF_FFFF_FFFF_FFFF), 1'b0);
    applyStimulus(32'hD3600C00); expectOut("lsl", 3'd1, 64'h3, 1'b0);
    step();
    checkOutput("drain.valid", 64'(out_valid), 64'd0);

    // Backpressure: fill main and skid, third word held off
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h14000001; step();
    instr = 32'h14000002; step();
    checkOutput("bp.in_ready_full", 64'(in_ready), 64'd0);
    expectOut("bp.hold1", 3'd4, bimm(64'h1), 1'b0);
    instr = 32'h14000003; step();
    checkOutput("bp.in_ready_held", 64'(in_ready), 64'd0);
    expectOut("bp.hold2", 3'd4, bimm(64'h1), 1'b0);
    out_ready = 1'b1; step();
    expectOut("bp.out2", 3'd4, bimm(64'h2), 1'b0);
    checkOutput("bp.in_ready_free", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    expectOut("bp.out3", 3'd4, bimm(64'h3), 1'b0);
    step();
    checkOutput("bp.empty", 64'(out_valid), 64'd0);

    // Flush with both entries full and an illegal word presented
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h14000005; step();
    instr = 32'h14000006; step();
    instr = 32'h00000000; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl.valid", 64'(out_valid), 64'd0);
    checkOutput("fl.in_ready", 64'(in_ready), 64'd1);
    checkOutput("fl.count", 64'(illegal_count), 64'd0);
    // Flush while the stage is able to accept: the illegal word is dropped and not counted
    applyStimulus(32'h14000009);
    in_valid = 1'b1; instr = 32'h00000000; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("fl2.valid", 64'(out_valid), 64'd0);
    checkOutput("fl2.count", 64'(illegal_count), 64'd0);
    out_ready = 1'b1; step();
    checkOutput("fl2.no_ghost", 64'(out_valid), 64'd0);

    // Illegal-opcode counter saturates at 15
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(32'h00000000);
      if (exp_cnt < 15) exp_cnt++;
      expectOut("ill", 3'd0, 64'd0, 1'b1);
      checkOutput("ill.count", 64'(illegal_count), 64'(exp_cnt));
    end
    step();

    // Reset with main/skid full and count=3
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'h00000000);
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h14000007; step();
    instr = 32'h14000008; step();
    in_valid = 1'b0;
    checkOutput("pre.count", 64'(illegal_count), 64'd3);
    checkOutput("pre.in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1; step(); reset = 1'b0;
    checkOutput("rst2.valid", 64'(out_valid), 64'd0);
    checkOutput("rst2.in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst2.imm", out_imm, 64'd0);
    checkOutput("rst2.kind", 64'(out_kind), 64'd0);
    checkOutput("rst2.illegal", 64'(out_illegal), 64'd0);
    checkOutput("rst2.count", 64'(illegal_count), 64'd0);
    out_ready = 1'b1;
    applyStimulus(32'hF85FF041); expectOut("post", 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    step();
    checkOutput("post.drain", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
